// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath is the master: it reports stage contents and receives the control and forwarding selects.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             id_is_bcond;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_sets_flags;
    logic [4:0]       ex_rn;
    logic [4:0]       ex_rm;
    logic             br_taken;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             mem_regwrite;
    logic             wb_regwrite;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
               ex_rd, ex_memread, ex_sets_flags, ex_rn, ex_rm, br_taken,
               mem_rd, wb_rd, mem_regwrite, wb_regwrite,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b,
               stall_cycles, flush_cycles
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
               ex_rd, ex_memread, ex_sets_flags, ex_rn, ex_rm, br_taken,
               mem_rd, wb_rd, mem_regwrite, wb_regwrite,
        output pc_we, ifid_we, ifid_flush, idex_bubble, fwd_a, fwd_b,
               stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and flag-use stalls,
// taken-branch flushes, EX operand forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 1,
    parameter int CNT_W             = 16
) (
    input logic        clk,
    input logic        reset,
    hazard_ctrl_if.slave hz
);
    localparam int MAX_P = (LOAD_STALL_CYCLES > BRANCH_PENALTY) ? LOAD_STALL_CYCLES : BRANCH_PENALTY;
    localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] LS_LOAD = CW'(LOAD_STALL_CYCLES - 1);
    localparam logic [CW-1:0] BP_LOAD = CW'(BRANCH_PENALTY - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FSTALL = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fuPrev_q, fuPrev_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic luHaz;
    logic fuHaz;
    logic brHaz;
    logic pcWe;
    logic ifidWe;
    logic ifidFlush;
    logic idexBubble;

    // XZR (register 31) is never a real producer, so it can never create a dependency.
    assign luHaz = hz.ex_memread && (hz.ex_rd != 5'd31) &&
                   ((hz.id_uses_rn && (hz.id_rn == hz.ex_rd)) ||
                    (hz.id_uses_rm && (hz.id_rm == hz.ex_rd)));
    assign fuHaz = hz.id_is_bcond && hz.ex_sets_flags;
    assign brHaz = hz.br_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            fuPrev_q   <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fuPrev_q   <= fuPrev_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    // A taken branch overrides everything, including an ongoing stall or an earlier flush.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pcWe       = 1'b1;
        ifidWe     = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;

        if (brHaz) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                state_d = FLUSH;
                cnt_d   = BP_LOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (luHaz) begin
                        pcWe       = 1'b0;
                        ifidWe     = 1'b0;
                        idexBubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LSTALL;
                            cnt_d   = LS_LOAD;
                        end
                    end else if (fuHaz) begin
                        pcWe       = 1'b0;
                        ifidWe     = 1'b0;
                        idexBubble = 1'b1;
                        if (fuPrev_q) begin
                            state_d = FSTALL;
                        end
                    end
                end
                LSTALL: begin
                    pcWe       = 1'b0;
                    ifidWe     = 1'b0;
                    idexBubble = 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                FSTALL: begin
                    pcWe       = 1'b0;
                    ifidWe     = 1'b0;
                    idexBubble = 1'b1;
                    state_d    = RUN;
                end
                FLUSH: begin
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Counters stick at all-ones so a long debug run never wraps back to a small value.
    always_comb begin
        fuPrev_d   = fuHaz;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (!pcWe && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (ifidFlush && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    // The youngest producer (EX/MEM) holds the newest value, so it beats MEM/WB.
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (hz.mem_regwrite && (hz.mem_rd != 5'd31) && (hz.mem_rd == hz.ex_rn)) begin
            hz.fwd_a = 2'b10;
        end else if (hz.wb_regwrite && (hz.wb_rd != 5'd31) && (hz.wb_rd == hz.ex_rn)) begin
            hz.fwd_a = 2'b01;
        end
        if (hz.mem_regwrite && (hz.mem_rd != 5'd31) && (hz.mem_rd == hz.ex_rm)) begin
            hz.fwd_b = 2'b10;
        end else if (hz.wb_regwrite && (hz.wb_rd != 5'd31) && (hz.wb_rd == hz.ex_rm)) begin
            hz.fwd_b = 2'b01;
        end
    end

    assign hz.pc_we        = pcWe;
    assign hz.ifid_we      = ifidWe;
    assign hz.ifid_flush   = ifidFlush;
    assign hz.idex_bubble  = idexBubble;
    assign hz.stall_cycles = stallCnt_q;
    assign hz.flush_cycles = flushCnt_q;

    // A flag-use stall bubbles the flag setter out of EX, so the hazard can never repeat back to back.
    flagUseOnce: assert property (@(posedge clk) disable iff (reset) !(fuPrev_q && fuHaz && !brHaz))
        else $error("hazard_ctrl: flag-use hazard persisted for two consecutive cycles");

endmodule
